// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: conditions one raw push-button for the display counter.
// Synchronises btn_raw, debounces it with a stable-count FSM and produces a
// clean level plus single-cycle press/release strobes.
//
// Optional feature: define BTN_AUTOREPEAT_EN to add auto-repeat press pulses
// while the button is held (REPEAT_DELAY, then every REPEAT_RATE cycles).
//
// Ports:
//   clock         in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   btn_raw       in   raw button, active-high, asynchronous to clock
//   btn_level     out  debounced button level
//   press_pulse   out  one-cycle strobe per accepted press (and per repeat)
//   release_pulse out  one-cycle strobe per accepted release
module btn_debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned REPEAT_DELAY    = 500,
    parameter int unsigned REPEAT_RATE     = 100
) (
    input  logic clock,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned CNT_NEED_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned CNT_NEED   = (CNT_NEED_A > REPEAT_RATE) ? CNT_NEED_A : REPEAT_RATE;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Elaboration-time parameter sanity checks
    if (DEBOUNCE_CYCLES < 2) begin : g_err_db
        $error("btn_debounce_pulse: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_RATE == 0) begin : g_err_rate
        $error("btn_debounce_pulse: REPEAT_RATE must be >= 1");
    end
    if ((64'(1) << CNT_W) <= 64'(CNT_NEED)) begin : g_err_w
        $error("btn_debounce_pulse: CNT_W too narrow for configured counts");
    end

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic             s0_q;
    logic             btn_s_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_level_q, btn_level_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic             repeat_hit;

    // Two-flop synchroniser for the asynchronous contact
    always_ff @(posedge clock) begin
        if (rst) begin
            s0_q    <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            s0_q    <= btn_raw;
            btn_s_q <= s0_q;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_s_q) state_d = ST_PRESS_WAIT;
            end
            ST_PRESS_WAIT: begin
                if (!btn_s_q)              state_d = ST_IDLE;
                else if (cnt_q == DB_LAST) state_d = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (!btn_s_q) state_d = ST_RELEASE_WAIT;
            end
            ST_RELEASE_WAIT: begin
                if (btn_s_q)               state_d = ST_PRESSED;
                else if (cnt_q == DB_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / counter next values; counter stops at DB_LAST since the state exits there
    always_comb begin
        cnt_d           = cnt_q;
        btn_level_d     = btn_level_q;
        press_pulse_d   = repeat_hit;
        release_pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_s_q) cnt_d = CNT_ONE;
            end
            ST_PRESS_WAIT: begin
                if (state_d == ST_PRESSED) begin
                    btn_level_d   = 1'b1;
                    press_pulse_d = 1'b1;
                end else if (btn_s_q) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!btn_s_q) cnt_d = CNT_ONE;
            end
            ST_RELEASE_WAIT: begin
                if (state_d == ST_IDLE) begin
                    btn_level_d     = 1'b0;
                    release_pulse_d = 1'b1;
                end else if (!btn_s_q) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and debounce counter
    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_q           <= '0;
            btn_level_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            btn_level_q     <= btn_level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_DELAY_C = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_RATE_C  = CNT_W'(REPEAT_RATE);

    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [CNT_W-1:0] rcnt_nxt;
    logic             rep_phase_q, rep_phase_d;

    // Repeat timer: counts PRESSED cycles up to REPEAT_DELAY, then restarts
    // from zero with REPEAT_RATE as terminal; holds through RELEASE_WAIT.
    always_comb begin
        rcnt_d      = rcnt_q;
        rep_phase_d = rep_phase_q;
        repeat_hit  = 1'b0;
        rcnt_nxt    = rcnt_q + CNT_ONE;
        if ((state_q == ST_PRESS_WAIT && state_d == ST_PRESSED) || state_d == ST_IDLE) begin
            rcnt_d      = '0;
            rep_phase_d = 1'b0;
        end else if (state_q == ST_PRESSED) begin
            if (rcnt_nxt >= (rep_phase_q ? REP_RATE_C : REP_DELAY_C)) begin
                repeat_hit  = 1'b1;
                rcnt_d      = '0;
                rep_phase_d = 1'b1;
            end else begin
                rcnt_d = rcnt_nxt;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            rcnt_q      <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rcnt_q      <= rcnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench for btn_debounce_pulse (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_RATE=3). Stimulus pushes the expected strobes (edge number + kind);
// a negedge monitor pops and compares whenever a strobe appears.
module tb_btn_debounce_pulse;

    logic clock = 1'b0;
    logic rst;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;

    always #5 clock = ~clock;

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    typedef struct {
        int unsigned edge_no;
        bit          is_press;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned edge_n = 0;
    int          n_vec  = 0;
    int          n_err  = 0;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic push_exp(input int unsigned e, input bit is_press);
        exp_t x;
        x.edge_no  = e;
        x.is_press = is_press;
        exp_q.push_back(x);
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_n, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: every strobe must match the head of the expected queue
    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
            n_vec++;
            n_err++;
            $display("FAIL missing_%s: expected at edge %0d, no strobe by edge %0d",
                     exp_q[0].is_press ? "press" : "release", exp_q[0].edge_no, edge_n);
            void'(exp_q.pop_front());
        end
        if (press_pulse === 1'b1 || release_pulse === 1'b1) begin
            n_vec++;
            if (press_pulse === 1'b1 && release_pulse === 1'b1) begin
                n_err++;
                $display("FAIL both_pulses at edge %0d: press=1 release=1, required at most one", edge_n);
            end else if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse at edge %0d: press=%b release=%b, required none",
                         edge_n, press_pulse, release_pulse);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                if (x.edge_no != edge_n || press_pulse !== logic'(x.is_press) ||
                    btn_level !== logic'(x.is_press)) begin
                    n_err++;
                    $display("FAIL pulse_match at edge %0d: press=%b release=%b level=%b, required %s at edge %0d level=%b",
                             edge_n, press_pulse, release_pulse, btn_level,
                             x.is_press ? "press" : "release", x.edge_no, x.is_press);
                end
            end
        end
    end

    initial begin
        int unsigned e;
        logic bounce[6];
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst     = 1'b1;
        btn_raw = 1'b0;

        // Reset / idle
        wait_n(2);
        check("rst_level", btn_level, 1'b0);
        check("rst_press", press_pulse, 1'b0);
        check("rst_release", release_pulse, 1'b0);
        wait_n(1);
        rst = 1'b0;
        wait_n(20);
        check("idle_level", btn_level, 1'b0);
        check("idle_press", press_pulse, 1'b0);
        check("idle_release", release_pulse, 1'b0);

        // Clean press and release
        e = edge_n;
        btn_raw = 1'b1;
        push_exp(e + 6, 1'b1);
        wait_n(8);
        check("clean_level_high", btn_level, 1'b1);
        btn_raw = 1'b0;
        push_exp(edge_n + 6, 1'b0);
        wait_n(12);
        check("clean_level_low", btn_level, 1'b0);

        // Bounce shorter than the debounce window
        foreach (bounce[i]) begin
            btn_raw = bounce[i];
            wait_n(1);
        end
        btn_raw = 1'b0;
        wait_n(12);
        check("bounce_level", btn_level, 1'b0);

        // Two-cycle low glitch while held
        e = edge_n;
        btn_raw = 1'b1;
        push_exp(e + 6, 1'b1);
        wait_n(8);
        btn_raw = 1'b0;
        wait_n(2);
        btn_raw = 1'b1;
        wait_n(2);
        check("glitch_level", btn_level, 1'b1);
        btn_raw = 1'b0;
        push_exp(edge_n + 6, 1'b0);
        wait_n(12);

        // Reset at edge 4 of a press debounce, button still held afterwards
        e = edge_n;
        btn_raw = 1'b1;
        wait_n(3);
        rst = 1'b1;
        wait_n(2);
        check("rst_mid_db_level", btn_level, 1'b0);
        check("rst_mid_db_press", press_pulse, 1'b0);
        rst = 1'b0;
        push_exp(edge_n + 6, 1'b1);
        wait_n(8);
        btn_raw = 1'b0;
        push_exp(edge_n + 6, 1'b0);
        wait_n(12);

        // Reset while pressed: level drops, no release strobe
        btn_raw = 1'b1;
        push_exp(edge_n + 6, 1'b1);
        wait_n(8);
        check("pre_rst_level", btn_level, 1'b1);
        rst = 1'b1;
        btn_raw = 1'b0;
        wait_n(1);
        check("rst_pressed_level", btn_level, 1'b0);
        check("rst_pressed_release", release_pulse, 1'b0);
        wait_n(1);
        rst = 1'b0;
        wait_n(12);

        // Long hold: repeats only with auto-repeat compiled in
        e = edge_n;
        btn_raw = 1'b1;
        push_exp(e + 6, 1'b1);
`ifdef BTN_AUTOREPEAT_EN
        push_exp(e + 16, 1'b1);
        push_exp(e + 19, 1'b1);
        push_exp(e + 22, 1'b1);
        push_exp(e + 25, 1'b1);
        push_exp(e + 28, 1'b1);
        push_exp(e + 31, 1'b1);
        push_exp(e + 34, 1'b1);
`endif
        wait_n(33);
        check("hold_level", btn_level, 1'b1);
        btn_raw = 1'b0;
        push_exp(edge_n + 6, 1'b0);
        wait_n(20);
        check("hold_end_level", btn_level, 1'b0);

        // Every expected strobe must have been consumed
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected strobes outstanding, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
